// File: rtl/vend_controller_pkg.sv
// Shared definitions for the vending controller: keypad codes (same values
// keypad_map emits), FSM state encoding and a small elaboration helper.
package vend_controller_pkg;

  localparam logic [2:0] KEY_NONE   = 3'b000;
  localparam logic [2:0] KEY_100    = 3'b001;
  localparam logic [2:0] KEY_500    = 3'b010;
  localparam logic [2:0] KEY_CANDY  = 3'b101;
  localparam logic [2:0] KEY_CHANGE = 3'b110;
  localparam logic [2:0] KEY_CLEAR  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPENSE = 2'd1,
    ST_CHANGE   = 2'd2
  } state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/vend_controller_key_event.sv
// Key event detector: registers the keypad code and emits a one-cycle event
// on each 000 -> non-zero transition, so a held key acts only once.
module vend_controller_key_event
  import vend_controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] key_code,
  output logic       evt_valid,
  output logic [2:0] evt_code
);

  logic [2:0] key_q;
  logic       evt_valid_q;
  logic [2:0] evt_code_q;

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_q       <= KEY_NONE;
      evt_valid_q <= 1'b0;
      evt_code_q  <= KEY_NONE;
    end else begin
      key_q       <= key_code;
      evt_valid_q <= (key_code != KEY_NONE) && (key_q == KEY_NONE);
      evt_code_q  <= key_code;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_code  = evt_code_q;

endmodule

// File: rtl/vend_controller.sv
// Vending sequencer: credit register, candy dispense timing and coin-by-coin
// change payout. Define VEND_TIMEOUT_EN to enable the idle auto-refund.
module vend_controller
  import vend_controller_pkg::*;
#(
  parameter int unsigned PRICE          = 3,
  parameter int unsigned MAX_CREDIT     = 15,
  parameter int unsigned DISP_CYCLES    = 8,
  parameter int unsigned COIN_CYCLES    = 4,
`ifdef VEND_TIMEOUT_EN
  parameter int unsigned TIMEOUT_CYCLES = 1000,
`endif
  localparam int unsigned CW = $clog2(MAX_CREDIT + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [2:0]    key_code,
  output logic [CW-1:0] credit,
  output logic          dispense,
  output logic          coin_out,
  output logic          coin_reject,
  output logic          err_funds,
  output logic          busy
);

  localparam int unsigned     CNT_LEN   = max_u(DISP_CYCLES, COIN_CYCLES);
  localparam int unsigned     CNT_W     = $clog2(CNT_LEN);
  localparam logic [CNT_W-1:0] DISP_LOAD = CNT_W'(DISP_CYCLES - 1);
  localparam logic [CNT_W-1:0] COIN_LOAD = CNT_W'(COIN_CYCLES - 1);
  localparam logic [CW-1:0]    PRICE_C   = CW'(PRICE);
  localparam logic [CW:0]      MAX_C     = (CW+1)'(MAX_CREDIT);

  state_e           state_q, state_d;
  logic [CW-1:0]    credit_q, credit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             coin_reject_q, coin_reject_d;
  logic             err_funds_q, err_funds_d;

  logic             evt_valid;
  logic [2:0]       evt_code;
  logic             is_coin;
  logic             clear_evt;
  logic             slot_start;
  logic [CW:0]      credit_sum;

`ifdef VEND_TIMEOUT_EN
  localparam int unsigned   TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0]            tmo_q, tmo_d;
`endif

  vend_controller_key_event u_key_event (
    .clk      (clk),
    .reset    (reset),
    .key_code (key_code),
    .evt_valid(evt_valid),
    .evt_code (evt_code)
  );

  assign is_coin    = evt_valid && ((evt_code == KEY_100) || (evt_code == KEY_500));
  assign clear_evt  = evt_valid && (evt_code == KEY_CLEAR);
  assign slot_start = (state_q == ST_CHANGE) && (cnt_q == COIN_LOAD);
  // One extra bit so an overflowing deposit is seen instead of wrapping.
  assign credit_sum = {1'b0, credit_q}
                    + ((evt_code == KEY_500) ? (CW+1)'(5) : (CW+1)'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      credit_q      <= '0;
      cnt_q         <= '0;
      coin_reject_q <= 1'b0;
      err_funds_q   <= 1'b0;
`ifdef VEND_TIMEOUT_EN
      tmo_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      cnt_q         <= cnt_d;
      coin_reject_q <= coin_reject_d;
      err_funds_q   <= err_funds_d;
`ifdef VEND_TIMEOUT_EN
      tmo_q         <= tmo_d;
`endif
    end
  end

  // NOTE: every signal gets a default first so no path infers a latch.
  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    cnt_d         = cnt_q;
    coin_reject_d = 1'b0;
    err_funds_d   = 1'b0;
`ifdef VEND_TIMEOUT_EN
    tmo_d         = '0;
`endif

    if (clear_evt) begin
      state_d  = ST_IDLE;
      credit_d = '0;
      cnt_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (evt_valid) begin
            case (evt_code)
              KEY_100, KEY_500: begin
                if (credit_sum <= MAX_C) credit_d = credit_sum[CW-1:0];
                else                     coin_reject_d = 1'b1;
              end
              KEY_CANDY: begin
                if (credit_q >= PRICE_C) begin
                  credit_d = credit_q - PRICE_C;
                  state_d  = ST_DISPENSE;
                  cnt_d    = DISP_LOAD;
                end else begin
                  err_funds_d = 1'b1;
                end
              end
              KEY_CHANGE: begin
                if (credit_q != '0) begin
                  state_d = ST_CHANGE;
                  cnt_d   = COIN_LOAD;
                end
              end
              default: ;
            endcase
          end
`ifdef VEND_TIMEOUT_EN
          else if (credit_q != '0) begin
            if (tmo_q == TMO_LAST) begin
              state_d = ST_CHANGE;
              cnt_d   = COIN_LOAD;
            end else begin
              tmo_d = tmo_q + TW'(1);
            end
          end
`endif
        end

        ST_DISPENSE: begin
          if (is_coin) coin_reject_d = 1'b1;
          if (cnt_q == '0) state_d = ST_IDLE;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end

        ST_CHANGE: begin
          if (is_coin)    coin_reject_d = 1'b1;
          if (slot_start) credit_d      = credit_q - CW'(1);
          // Slot ends: leave once the coin just paid was the last one.
          if (cnt_q == '0) begin
            if (credit_q == '0) state_d = ST_IDLE;
            else                cnt_d   = COIN_LOAD;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end

        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    credit      = credit_q;
    dispense    = (state_q == ST_DISPENSE);
    busy        = (state_q != ST_IDLE);
    coin_out    = slot_start && !clear_evt;
    coin_reject = coin_reject_q;
    err_funds   = err_funds_q;
  end

  a_reject_pulse: assert property (@(posedge clk) disable iff (reset)
    coin_reject |=> !coin_reject);
  a_err_pulse: assert property (@(posedge clk) disable iff (reset)
    err_funds |=> !err_funds);
  a_coin_pulse: assert property (@(posedge clk) disable iff (reset)
    coin_out |=> !coin_out);
  a_disp_busy: assert property (@(posedge clk) disable iff (reset)
    dispense |-> busy);

endmodule

// File: tb/tb_vend_controller.sv
// Directed bench for vend_controller: deposits, overflow, candy, change,
// abort and reset mid-dispense, with hand-computed expectations.
module tb_vend_controller;

  logic       clk;
  logic       reset;
  logic [2:0] key_code;
  logic [3:0] credit;
  logic       dispense, coin_out, coin_reject, err_funds, busy;

  int n_checks = 0;
  int n_pass   = 0;

  int cyc = 0;
  int n_coin = 0, n_rej = 0, n_err = 0, n_disp = 0, n_busy = 0;
  int coin_cyc[$];
  int credit_after[$];
  logic coin_prev = 1'b0;

  vend_controller #(
    .PRICE         (3),
    .MAX_CREDIT    (15),
    .DISP_CYCLES   (8),
`ifdef VEND_TIMEOUT_EN
    .TIMEOUT_CYCLES(50),
`endif
    .COIN_CYCLES   (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .key_code   (key_code),
    .credit     (credit),
    .dispense   (dispense),
    .coin_out   (coin_out),
    .coin_reject(coin_reject),
    .err_funds  (err_funds),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Output monitor on the falling edge, away from every register update.
  always @(negedge clk) begin
    cyc++;
    if (coin_prev) credit_after.push_back(int'(credit));
    if (coin_out) begin
      n_coin++;
      coin_cyc.push_back(cyc);
    end
    if (coin_reject) n_rej++;
    if (err_funds)   n_err++;
    if (dispense)    n_disp++;
    if (busy)        n_busy++;
    coin_prev = coin_out;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle key press, release, then a few settle cycles.
  task automatic press(input logic [2:0] code);
    key_code = code;
    step(1);
    key_code = 3'b000;
    step(3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c0, r0, e0, d0, b0, q0, a0, waited;
    reset    = 1'b1;
    key_code = 3'b000;
    step(3);
    check("rst_credit", credit, 0);
    check("rst_dispense", dispense, 0);
    check("rst_busy", busy, 0);
    check("rst_pulses", {coin_out, coin_reject, err_funds}, 0);
    reset = 1'b0;
    step(2);

    // Single deposits, then a held key counts once.
    press(3'b001); check("dep_1", credit, 1);
    press(3'b001); check("dep_2", credit, 2);
    press(3'b001); check("dep_3", credit, 3);
    key_code = 3'b001;
    step(20);
    key_code = 3'b000;
    step(3);
    check("hold_once", credit, 4);

    // Clear then candy with exact price.
    press(3'b111); check("clear_idle", credit, 0);
    press(3'b001); press(3'b001); press(3'b001);
    d0 = n_disp; b0 = n_busy;
    press(3'b101);
    check("candy_credit", credit, 0);
    step(10);
    check("candy_disp_cycles", n_disp - d0, 8);
    check("candy_busy_cycles", n_busy - b0, 8);
    check("candy_back_idle", {busy, dispense}, 0);

    // Insufficient funds.
    press(3'b001); press(3'b001);
    e0 = n_err; d0 = n_disp;
    press(3'b101);
    step(10);
    check("funds_err_pulse", n_err - e0, 1);
    check("funds_credit", credit, 2);
    check("funds_no_disp", n_disp - d0, 0);

    // Overflow at the ceiling.
    press(3'b010); press(3'b010);
    check("dep_12", credit, 12);
    r0 = n_rej;
    press(3'b010);
    check("ovf_500_reject", n_rej - r0, 1);
    check("ovf_500_credit", credit, 12);
    press(3'b001); press(3'b001); press(3'b001);
    check("dep_15", credit, 15);
    r0 = n_rej;
    press(3'b001);
    check("ovf_100_reject", n_rej - r0, 1);
    check("ovf_100_credit", credit, 15);

    // Change payout of 3 with a coin inserted mid-payout.
    press(3'b111);
    press(3'b001); press(3'b001); press(3'b001);
    c0 = n_coin; r0 = n_rej; b0 = n_busy;
    q0 = coin_cyc.size(); a0 = credit_after.size();
    press(3'b110);
    press(3'b001);
    step(16);
    check("chg_coin_count", n_coin - c0, 3);
    check("chg_busy_cycles", n_busy - b0, 12);
    check("chg_mid_reject", n_rej - r0, 1);
    check("chg_credit_end", credit, 0);
    check("chg_idle", busy, 0);
    for (int i = 0; i < 2; i++)
      check($sformatf("chg_gap_%0d", i),
            (coin_cyc.size() > q0 + i + 1) ? coin_cyc[q0+i+1] - coin_cyc[q0+i] : -1, 4);
    for (int i = 0; i < 3; i++)
      check($sformatf("chg_credit_step_%0d", i),
            (credit_after.size() > a0 + i) ? credit_after[a0+i] : -1, 2 - i);

    // Abort a payout of 4 after the first coin.
    press(3'b001); press(3'b001); press(3'b001); press(3'b001);
    c0 = n_coin;
    key_code = 3'b110;
    step(1);
    key_code = 3'b000;
    waited = 0;
    while (n_coin == c0 && waited < 20) begin
      step(1);
      waited++;
    end
    check("abort_first_coin", n_coin - c0, 1);
    press(3'b111);
    check("abort_credit", credit, 0);
    check("abort_idle", busy, 0);
    step(20);
    check("abort_no_more_coins", n_coin - c0, 1);

    // Change with zero credit does nothing.
    c0 = n_coin; b0 = n_busy;
    press(3'b110);
    step(4);
    check("chg_zero_busy", n_busy - b0, 0);
    check("chg_zero_coins", n_coin - c0, 0);

    // Reset mid-dispense: outputs drop without waiting for a clock.
    press(3'b010);
    press(3'b101);
    step(2);
    check("pre_rst_disp", {busy, dispense}, 2'b11);
    check("pre_rst_credit", credit, 2);
    reset = 1'b1;
    #2;
    check("async_rst_disp", {busy, dispense}, 0);
    check("async_rst_credit", credit, 0);
    #1;
    reset = 1'b0;
    step(10);
    check("post_rst_idle", {busy, dispense}, 0);

    // Idle with credit: refund only when the timeout is built in.
    press(3'b001); press(3'b001);
    c0 = n_coin;
    step(75);
`ifdef VEND_TIMEOUT_EN
    check("timeout_coins", n_coin - c0, 2);
    check("timeout_credit", credit, 0);
`else
    check("hold_credit_coins", n_coin - c0, 0);
    check("hold_credit", credit, 2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
